// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button debouncer.
// Exports the FSM state encoding and the synchronizer depth.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_press_debouncer_if.sv
// Button bundle: raw button in, debounced level and event pulses out.
// master = debouncer (drives events), slave = consumer (drives btn).
interface btn_press_debouncer_if;

    logic btn;
    logic btn_pressed;
    logic btn_released;
    logic btn_level;
    logic long_press;

    modport master (
        input  btn,
        output btn_pressed,
        output btn_released,
        output btn_level,
        output long_press
    );

    modport slave (
        output btn,
        input  btn_pressed,
        input  btn_released,
        input  btn_level,
        input  long_press
    );

endinterface

// File: rtl/sync_2ff.sv
// Single-bit flop synchronizer, depth SYNC_STAGES, async active-low clear.
// Ports: sysclk, reset_n, d (async input), q (synchronized output).
module sync_2ff
    import btn_pkg::*;
(
    input  logic sysclk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sr;

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/btn_press_debouncer.sv
// Debounces a raw push-button into a level plus press/release/long pulses.
// Ports: sysclk, reset_n (async, active-low), bus (master: btn in, events out).
module btn_press_debouncer
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_COUNT_THRESHOLD = 300,
    parameter int LONG_PRESS_COUNT         = 125000000
) (
    input  logic                   sysclk,
    input  logic                   reset_n,
    btn_press_debouncer_if.master  bus
);

    localparam int DW = $clog2(DEBOUNCE_COUNT_THRESHOLD + 1);
    localparam int HW = (LONG_PRESS_COUNT == 0) ? 1
                      : $clog2(LONG_PRESS_COUNT + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_COUNT_THRESHOLD - 1);
    localparam logic [DW-1:0] DEB_SAT   = DW'(DEBOUNCE_COUNT_THRESHOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_COUNT - 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_PRESS_COUNT);
    localparam bit            LONG_EN   = (LONG_PRESS_COUNT != 0);

    logic            s;
    btn_state_t      state;
    logic [DW-1:0]   deb_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            pressed_q;
    logic            released_q;
    logic            level_q;
    logic            long_q;

    sync_2ff u_sync (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .d       (bus.btn),
        .q       (s)
    );

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            hold_cnt   <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            level_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            long_q     <= 1'b0;
            case (state)
                IDLE: begin
                    level_q <= 1'b0;
                    if (s) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= HELD;
                        pressed_q <= 1'b1;
                        level_q   <= 1'b1;
                        hold_cnt  <= '0;
                    end else if (deb_cnt != DEB_SAT) begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                HELD: begin
                    if (!s) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= '0;
                    end else if (LONG_EN && hold_cnt == HOLD_LAST) begin
                        // Park at saturation so the pulse fires once per press.
                        long_q   <= 1'b1;
                        hold_cnt <= HOLD_SAT;
                    end else if (LONG_EN && hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                RELEASE_WAIT: begin
                    // hold_cnt frozen here so a release glitch does not lose hold time.
                    if (s) begin
                        state <= HELD;
                    end else if (deb_cnt == DEB_LAST) begin
                        state      <= IDLE;
                        released_q <= 1'b1;
                        level_q    <= 1'b0;
                        hold_cnt   <= '0;
                    end else if (deb_cnt != DEB_SAT) begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.btn_pressed  = pressed_q;
    assign bus.btn_released = released_q;
    assign bus.btn_level    = level_q;
    assign bus.long_press   = long_q;

endmodule

// File: tb/tb_btn_press_debouncer.sv
// Directed bench for btn_press_debouncer (THRESHOLD=4, LONG_PRESS_COUNT=10).
// Tallies event pulses per edge and checks counts and edge indices.
module tb_btn_press_debouncer;

    logic sysclk;
    logic reset_n;

    btn_press_debouncer_if bus ();

    btn_press_debouncer #(
        .DEBOUNCE_COUNT_THRESHOLD (4),
        .LONG_PRESS_COUNT         (10)
    ) dut (
        .sysclk  (sysclk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_run;
    int n_fail;
    int cyc;
    int press_cnt, rel_cnt, long_cnt, multi_cnt, low_cnt;
    int press_edge, rel_edge, long_edge;
    int k;

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_tally();
        press_cnt  = 0;
        rel_cnt    = 0;
        long_cnt   = 0;
        multi_cnt  = 0;
        low_cnt    = 0;
        press_edge = -1;
        rel_edge   = -1;
        long_edge  = -1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            cyc++;
            #1;
            if (bus.btn_pressed) begin
                press_cnt++;
                if (press_edge < 0) press_edge = cyc;
            end
            if (bus.btn_released) begin
                rel_cnt++;
                if (rel_edge < 0) rel_edge = cyc;
            end
            if (bus.long_press) begin
                long_cnt++;
                if (long_edge < 0) long_edge = cyc;
            end
            if (int'(bus.btn_pressed) + int'(bus.btn_released)
                + int'(bus.long_press) > 1) multi_cnt++;
            if (!bus.btn_level) low_cnt++;
        end
    endtask

    function automatic int outs();
        return {28'd0, bus.btn_pressed, bus.btn_released,
                bus.btn_level, bus.long_press};
    endfunction

    initial begin
        n_run   = 0;
        n_fail  = 0;
        cyc     = 0;
        reset_n = 1'b0;
        bus.btn = 1'b0;
        clear_tally();

        step(3);
        check("reset_outs", outs(), 0);
        reset_n = 1'b1;
        step(3);
        check("idle_outs", outs(), 0);

        // Clean press
        clear_tally();
        bus.btn = 1'b1;
        k = cyc + 1;
        step(5);
        check("press_lvl_k4", int'(bus.btn_level), 0);
        step(1);
        check("press_k5", outs(), 0);
        step(1);
        check("press_k6_pulse", int'(bus.btn_pressed), 1);
        check("press_k6_level", int'(bus.btn_level), 1);
        step(23);
        check("press_count", press_cnt, 1);
        check("press_edge", press_edge, k + 6);
        check("long_edge", long_edge, k + 16);
        check("long_count", long_cnt, 1);
        check("press_no_rel", rel_cnt, 0);

        // Release
        clear_tally();
        bus.btn = 1'b0;
        k = cyc + 1;
        step(5);
        check("rel_lvl_r4", int'(bus.btn_level), 1);
        step(1);
        check("rel_r5_pulse", int'(bus.btn_released), 0);
        step(1);
        check("rel_r6_pulse", int'(bus.btn_released), 1);
        check("rel_r6_level", int'(bus.btn_level), 0);
        step(10);
        check("rel_count", rel_cnt, 1);
        check("rel_edge", rel_edge, k + 6);
        check("rel_no_press", press_cnt + long_cnt, 0);

        // Press bounce
        clear_tally();
        bus.btn = 1'b1; step(3);
        bus.btn = 1'b0; step(2);
        bus.btn = 1'b1; step(2);
        bus.btn = 1'b0; step(1);
        bus.btn = 1'b1;
        k = cyc + 1;
        step(20);
        check("bounce_count", press_cnt, 1);
        check("bounce_edge", press_edge, k + 6);

        // Long press: no repeat while held
        clear_tally();
        step(50);
        check("long_no_repeat", long_cnt, 0);
        check("long_no_press", press_cnt, 0);
        bus.btn = 1'b0;
        step(10);
        clear_tally();
        bus.btn = 1'b1;
        k = cyc + 1;
        step(30);
        check("repress_long_cnt", long_cnt, 1);
        check("repress_long_edge", long_edge, k + 16);
        check("repress_edge", press_edge, k + 6);

        // Release glitch, hold_cnt frozen through RELEASE_WAIT
        bus.btn = 1'b0;
        step(10);
        bus.btn = 1'b1;
        k = cyc + 1;
        step(8);
        clear_tally();
        bus.btn = 1'b0; step(2);
        bus.btn = 1'b1;
        step(30);
        check("glitch_no_rel", rel_cnt, 0);
        check("glitch_no_press", press_cnt, 0);
        check("glitch_level_low", low_cnt, 0);
        check("glitch_long_edge", long_edge, k + 19);

        // Reset during HELD clears level at once
        reset_n = 1'b0;
        #1;
        check("rst_held_outs", outs(), 0);
        bus.btn = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(3);

        // Reset mid-press, then fresh press with btn still high
        bus.btn = 1'b1;
        step(4);
        reset_n = 1'b0;
        #1;
        check("rst_pw_outs", outs(), 0);
        step(3);
        check("rst_hold_outs", outs(), 0);
        clear_tally();
        reset_n = 1'b1;
        k = cyc + 1;
        step(10);
        check("rst_press_cnt", press_cnt, 1);
        check("rst_press_edge", press_edge, k + 6);
        check("mutex_all", multi_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
